output_port_allocator: RTL and testbench

Wormhole output-port allocator for one router output (N, S, E, W or L). It arbitrates packet ownership of the output among the five input VC buffers, using round-robin priority among head flits, and holds the grant until the owning packet's tail flit has passed. It also gates every flit transfer on a downstream credit counter. It drives the crossbar select for its output and the pop strobes of the input buffers.

---
 rtl/noc_pkg.sv | 24 ++
 rtl/rr_pick5.sv | 32 +++
 rtl/output_port_allocator.sv | 123 ++++++++++++
 tb/tb_output_port_allocator.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port codes, flit type codes and the
// output-allocator FSM state encoding.
package noc_pkg;

    localparam int NUM_PORTS = 5;

    localparam logic [2:0] PORT_N       = 3'd0;
    localparam logic [2:0] PORT_S       = 3'd1;
    localparam logic [2:0] PORT_E       = 3'd2;
    localparam logic [2:0] PORT_W       = 3'd3;
    localparam logic [2:0] PORT_L       = 3'd4;
    localparam logic [2:0] PORT_INVALID = 3'd7;

    localparam logic [1:0] FLIT_BODY     = 2'b00;
    localparam logic [1:0] FLIT_HEAD     = 2'b01;
    localparam logic [1:0] FLIT_TAIL     = 2'b10;
    localparam logic [1:0] FLIT_HEADTAIL = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } alloc_state_t;

endpackage

// File: rtl/rr_pick5.sv
// Rotating-priority picker over five requesters: searches ptr+1, ptr+2, ...
// wrapping 4->0, with ptr itself as the last candidate.
module rr_pick5
    import noc_pkg::*;
(
    input  logic [4:0] eligible,
    input  logic [2:0] ptr,
    output logic       found,
    output logic [2:0] idx
);

    logic [3:0] cand;

    // NOTE: combinational outputs get a default before any conditional
    // assignment so no path leaves them unassigned, which would infer a latch.
    always_comb begin
        found = 1'b0;
        idx   = 3'd0;
        cand  = 4'd0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = {1'b0, ptr} + 4'(k);
            // Two folds keep the index in range even for an out-of-range ptr.
            if (cand >= 4'(NUM_PORTS)) cand = cand - 4'(NUM_PORTS);
            if (cand >= 4'(NUM_PORTS)) cand = cand - 4'(NUM_PORTS);
            if (!found && eligible[cand[2:0]]) begin
                found = 1'b1;
                idx   = cand[2:0];
            end
        end
    end

endmodule

// File: rtl/output_port_allocator.sv
// Wormhole allocator for one router output: round-robin grant among head
// flits, packet lock until tail, and credit-gated transfers.
module output_port_allocator
    import noc_pkg::*;
#(
    parameter int BUF_DEPTH = 4,
    parameter int CW        = $clog2(BUF_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    in_valid,
    input  logic [9:0]    in_type,
    input  logic          credit_in,
    output logic [4:0]    pop,
    output logic [2:0]    out_sel,
    output logic          out_valid,
    output logic [CW-1:0] credits,
    output logic          credit_err,
    output logic          busy
);

    localparam logic [CW-1:0] CREDITS_FULL = CW'(BUF_DEPTH);

    alloc_state_t state, state_next;
    logic [2:0]   owner, owner_next;
    logic [2:0]   rr_ptr, rr_next;

    logic [4:0] eligible;
    logic       win_found;
    logic [2:0] win_idx;
    logic [1:0] win_type;
    logic [1:0] owner_type;
    logic       owner_valid;
    logic       can_send;

    // Only HEAD and HEADTAIL (type bit 0 set) may open a new packet.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            eligible[i] = in_valid[i] && in_type[2*i];
        end
    end

    rr_pick5 u_pick (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .found    (win_found),
        .idx      (win_idx)
    );

    always_comb begin
        win_type    = FLIT_BODY;
        owner_type  = FLIT_BODY;
        owner_valid = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (win_idx == 3'(i)) win_type = in_type[2*i +: 2];
            if (owner == 3'(i)) begin
                owner_type  = in_type[2*i +: 2];
                owner_valid = in_valid[i];
            end
        end
    end

    assign can_send = (credits != '0);

    always_comb begin
        state_next = state;
        owner_next = owner;
        rr_next    = rr_ptr;
        pop        = 5'b0;
        out_sel    = PORT_INVALID;
        if (!reset) begin
            unique case (state)
                ST_IDLE: begin
                    if (win_found && can_send) begin
                        pop     = 5'b00001 << win_idx;
                        out_sel = win_idx;
                        rr_next = win_idx;
                        if (win_type == FLIT_HEAD) begin
                            state_next = ST_LOCKED;
                            owner_next = win_idx;
                        end
                    end
                end
                ST_LOCKED: begin
                    out_sel = owner;
                    // A stray HEAD at the owner passes as BODY: only TAIL/HEADTAIL release.
                    if (owner_valid && can_send) begin
                        pop = 5'b00001 << owner;
                        if (owner_type == FLIT_TAIL || owner_type == FLIT_HEADTAIL)
                            state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign out_valid = |pop;
    assign busy      = (state == ST_LOCKED);

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            owner      <= PORT_N;
            rr_ptr     <= PORT_L;
            credits    <= CREDITS_FULL;
            credit_err <= 1'b0;
        end else begin
            state  <= state_next;
            owner  <= owner_next;
            rr_ptr <= rr_next;
            if (out_valid && !credit_in) begin
                credits <= credits - 1'b1;
            end else if (!out_valid && credit_in) begin
                if (credits == CREDITS_FULL) credit_err <= 1'b1;
                else                         credits    <= credits + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_output_port_allocator.sv
// Scoreboard bench: stimulus pushes expected transfers, monitors pop and
// compare whenever a DUT presents out_valid.
module tb_output_port_allocator;
    import noc_pkg::*;

    typedef struct {
        logic [2:0] sel;
        logic [4:0] pop;
    } xfer_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] in_valid, in_valid2;
    logic [9:0] in_type, in_type2;
    logic       credit_in, credit_in2;

    logic [4:0] pop, pop2;
    logic [2:0] out_sel, out_sel2;
    logic       out_valid, out_valid2;
    logic [2:0] credits;
    logic [1:0] credits2;
    logic       credit_err, credit_err2;
    logic       busy, busy2;

    int n_tests = 0;
    int n_fail  = 0;
    xfer_t q[$];
    xfer_t q2[$];

    always #5 clk = ~clk;

    output_port_allocator dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_type(in_type),
        .credit_in(credit_in), .pop(pop), .out_sel(out_sel), .out_valid(out_valid),
        .credits(credits), .credit_err(credit_err), .busy(busy)
    );

    output_port_allocator #(.BUF_DEPTH(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_type(in_type2),
        .credit_in(credit_in2), .pop(pop2), .out_sel(out_sel2), .out_valid(out_valid2),
        .credits(credits2), .credit_err(credit_err2), .busy(busy2)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [9:0] ty(input int p, input logic [1:0] f);
        logic [9:0] t;
        t = '0;
        t[2*p +: 2] = f;
        return t;
    endfunction

    task automatic drive(input logic [4:0] v, input logic [9:0] t, input logic c);
        in_valid = v; in_type = t; credit_in = c;
    endtask

    task automatic drive2(input logic [4:0] v, input logic [9:0] t, input logic c);
        in_valid2 = v; in_type2 = t; credit_in2 = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_xfer(input logic [2:0] sel);
        xfer_t x;
        x.sel = sel;
        x.pop = 5'b00001 << sel;
        q.push_back(x);
    endtask

    task automatic expect_xfer2(input logic [2:0] sel);
        xfer_t x;
        x.sel = sel;
        x.pop = 5'b00001 << sel;
        q2.push_back(x);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drive(5'b11111, {5{FLIT_HEADTAIL}}, 1'b1);
        drive2(5'b0, '0, 1'b0);
        #1;
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_out_sel", 32'(out_sel), 7);
        step();
        step();
        reset = 1'b0;
        drive(5'b0, '0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_xfer: got sel=%0d pop=%b, expected no transfer", out_sel, pop);
            end else begin
                xfer_t e;
                e = q.pop_front();
                check("xfer_sel", 32'(out_sel), 32'(e.sel));
                check("xfer_pop", 32'(pop), 32'(e.pop));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && out_valid2) begin
            if (q2.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_xfer2: got sel=%0d pop=%b, expected no transfer", out_sel2, pop2);
            end else begin
                xfer_t e;
                e = q2.pop_front();
                check("xfer2_sel", 32'(out_sel2), 32'(e.sel));
                check("xfer2_pop", 32'(pop2), 32'(e.pop));
            end
        end
    end

    initial begin
        reset = 1'b1;
        drive(5'b0, '0, 1'b0);
        drive2(5'b0, '0, 1'b0);
        step();
        apply_reset();
        check("rst_credits", 32'(credits), 4);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(credit_err), 0);
        check("rst_credits2", 32'(credits2), 2);

        // Single packet from E: HEAD, BODY, TAIL.
        drive(5'b00100, ty(2, FLIT_HEAD), 1'b0); expect_xfer(PORT_E); step();
        check("pkt_busy_h", 32'(busy), 1);
        check("pkt_cred_h", 32'(credits), 3);
        drive(5'b00100, ty(2, FLIT_BODY), 1'b0); expect_xfer(PORT_E); step();
        check("pkt_cred_b", 32'(credits), 2);
        drive(5'b00100, ty(2, FLIT_TAIL), 1'b0); expect_xfer(PORT_E); step();
        check("pkt_busy_t", 32'(busy), 0);
        check("pkt_cred_t", 32'(credits), 1);
        drive(5'b00100, ty(2, FLIT_BODY), 1'b0); #1;
        check("idle_body_ignored", 32'(out_sel), 7);
        step();
        drive(5'b0, '0, 1'b1); step(); step(); step();
        check("pkt_refill", 32'(credits), 4);
        check("pkt_q_empty", 32'(q.size()), 0);

        // Credit stall on the BUF_DEPTH=2 instance, 4-flit packet from L.
        drive2(5'b10000, ty(4, FLIT_HEAD), 1'b0); expect_xfer2(PORT_L); step();
        check("st_cred1", 32'(credits2), 1);
        drive2(5'b10000, ty(4, FLIT_BODY), 1'b0); expect_xfer2(PORT_L); step();
        check("st_cred0", 32'(credits2), 0);
        drive2(5'b10000, ty(4, FLIT_BODY), 1'b0); step();
        check("st_stall_busy", 32'(busy2), 1);
        drive2(5'b10000, ty(4, FLIT_BODY), 1'b1); step();
        check("st_credit_back", 32'(credits2), 1);
        drive2(5'b10000, ty(4, FLIT_BODY), 1'b0); expect_xfer2(PORT_L); step();
        check("st_cred0_again", 32'(credits2), 0);
        drive2(5'b10000, ty(4, FLIT_TAIL), 1'b1); step();
        check("st_tail_held", 32'(busy2), 1);
        drive2(5'b10000, ty(4, FLIT_TAIL), 1'b0); expect_xfer2(PORT_L); step();
        check("st_tail_done", 32'(busy2), 0);
        drive2(5'b0, '0, 1'b0); step();
        check("st_q_empty", 32'(q2.size()), 0);

        // Round-robin with every port offering HEADTAIL and credits returning.
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive(5'b11111, {5{FLIT_HEADTAIL}}, 1'b1);
            expect_xfer(3'(i % 5));
            step();
            check("rr_credits", 32'(credits), 4);
        end
        drive(5'b0, '0, 1'b0); step();
        check("rr_q_empty", 32'(q.size()), 0);

        // Lock hold: S owns the output while N waits with a HEAD.
        drive(5'b00010, ty(1, FLIT_HEAD), 1'b0); expect_xfer(PORT_S); step();
        drive(5'b00011, ty(1, FLIT_BODY) | ty(0, FLIT_HEAD), 1'b0); #1;
        check("lock_sel", 32'(out_sel), 1);
        expect_xfer(PORT_S); step();
        drive(5'b00011, ty(1, FLIT_TAIL) | ty(0, FLIT_HEAD), 1'b0); expect_xfer(PORT_S); step();
        check("lock_released", 32'(busy), 0);
        drive(5'b00001, ty(0, FLIT_HEAD), 1'b0); expect_xfer(PORT_N); step();
        check("lock_n_busy", 32'(credits), 0);
        drive(5'b00001, ty(0, FLIT_TAIL), 1'b1); step();
        drive(5'b00001, ty(0, FLIT_TAIL), 1'b0); expect_xfer(PORT_N); step();
        check("lock_n_done", 32'(busy), 0);
        drive(5'b0, '0, 1'b1); step(); step(); step(); step();
        check("lock_refill", 32'(credits), 4);

        // Credit overflow is sticky until reset.
        drive(5'b0, '0, 1'b1); step();
        check("ovf_credits", 32'(credits), 4);
        check("ovf_err", 32'(credit_err), 1);
        drive(5'b01000, ty(3, FLIT_HEADTAIL), 1'b0); expect_xfer(PORT_W); step();
        check("ovf_err_sticky", 32'(credit_err), 1);
        check("ovf_cred3", 32'(credits), 3);

        // Reset while W holds the lock; N's pending HEAD wins afterwards.
        drive(5'b01000, ty(3, FLIT_HEAD), 1'b0); expect_xfer(PORT_W); step();
        check("mid_locked", 32'(busy), 1);
        reset = 1'b1;
        drive(5'b01001, ty(3, FLIT_BODY) | ty(0, FLIT_HEAD), 1'b0); #1;
        check("mid_rst_valid", 32'(out_valid), 0);
        step();
        reset = 1'b0;
        drive(5'b0, '0, 1'b0); #1;
        check("mid_idle", 32'(busy), 0);
        check("mid_sel", 32'(out_sel), 7);
        check("mid_credits", 32'(credits), 4);
        check("mid_err_clr", 32'(credit_err), 0);
        drive(5'b00001, ty(0, FLIT_HEADTAIL), 1'b0); expect_xfer(PORT_N); step();
        drive(5'b0, '0, 1'b0); step(); step();
        check("final_q_empty", 32'(q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
